mips_multicycle_control: RTL

//  Moore FSM sequencing the multicycle MIPS datapath around the shared ALU, register file, memory and PC.

---
 rtl/mips_pkg.sv | 73 +++++++
 rtl/mips_alu_control.sv | 35 +++
 rtl/mips_multicycle_control.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS control path:
// opcodes, funct codes, ALU operation codes, FSM states and the control word.
package mips_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_BAD = 4'b1111;

    // ALUOP_NONE parks the ALU code at 0000 in states that do not use the ALU
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_e;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_BNE    = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_beq;
        logic       pc_bne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_control.sv
// Combinational ALU decoder: ALUOp class plus Funct field to the 4-bit ALU code.
module mips_alu_control
    import mips_pkg::*;
(
    input  aluop_e               alu_op,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALU_OP_W-1:0]  alu_operation,
    output logic                 funct_illegal
);

    always_comb begin
        alu_operation = ALU_AND;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_operation = ALU_ADD;
            ALUOP_SUB: alu_operation = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_operation = ALU_ADD;
                    FN_SUB:  alu_operation = ALU_SUB;
                    FN_AND:  alu_operation = ALU_AND;
                    FN_OR:   alu_operation = ALU_OR;
                    FN_SLT:  alu_operation = ALU_SLT;
                    FN_NOR:  alu_operation = ALU_NOR;
                    default: begin
                        alu_operation = ALU_BAD;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alu_operation = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: decodes Opcode/Funct and
// drives per-state enables, mux selects and the ALU operation code.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter bit EN_BNE  = 1'b1,
    parameter bit EN_ADDI = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     Opcode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Zero,
    output logic                PCEn,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALU_OP_W-1:0] ALUOperation,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    state_e                state_q;
    state_e                state_d;
    ctrl_t                 ctrl;
    aluop_e                alu_op;
    logic [ALU_OP_W-1:0]   alu_code;
    logic                  funct_illegal;
    logic                  op_illegal;
    logic                  done;
    logic                  funct_bad_q;
    logic                  pc_take;

    mips_alu_control u_alu_control (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_operation (alu_code),
        .funct_illegal (funct_illegal)
    );

    // State register; the bad-funct flag is captured when leaving EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            funct_bad_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXEC) begin
                funct_bad_q <= funct_illegal;
            end
        end
    end

    // Next-state and per-state control word
    always_comb begin
        state_d    = S_FETCH;
        ctrl       = '0;
        alu_op     = ALUOP_NONE;
        op_illegal = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.pc_write  = 1'b1;
                alu_op         = ALUOP_ADD;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                alu_op         = ALUOP_ADD;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE: begin
                        if (EN_BNE) state_d = S_BNE;
                        else        op_illegal = 1'b1;
                    end
                    OP_ADDI: begin
                        if (EN_ADDI) state_d = S_ADDIEX;
                        else         op_illegal = 1'b1;
                    end
                    default:      op_illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                alu_op         = ALUOP_ADD;
                if (state_q == S_ADDIEX)  state_d = S_ADDIWB;
                else if (Opcode == OP_LW) state_d = S_MEMRD;
                else if (Opcode == OP_SW) state_d = S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = S_MEMWB;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                done           = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                done            = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                alu_op         = ALUOP_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = ~funct_bad_q;
                ctrl.reg_dst   = 1'b1;
                done           = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                done           = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.pc_source = 2'b01;
                ctrl.pc_beq    = (state_q == S_BEQ);
                ctrl.pc_bne    = (state_q == S_BNE);
                alu_op         = ALUOP_SUB;
                done           = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = 2'b10;
                ctrl.pc_write  = 1'b1;
                done           = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pc_take = ctrl.pc_write | (ctrl.pc_beq & Zero) | (ctrl.pc_bne & ~Zero);

    // Everything but the debug state is held at zero while reset is asserted
    always_comb begin
        PCEn         = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        ALUOperation = '0;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        state        = state_q;
        if (!reset) begin
            PCEn         = pc_take;
            IorD         = ctrl.iord;
            MemRead      = ctrl.mem_read;
            MemWrite     = ctrl.mem_write;
            IRWrite      = ctrl.ir_write;
            RegDst       = ctrl.reg_dst;
            MemtoReg     = ctrl.mem_to_reg;
            RegWrite     = ctrl.reg_write;
            ALUSrcA      = ctrl.alu_src_a;
            ALUSrcB      = ctrl.alu_src_b;
            PCSource     = ctrl.pc_source;
            ALUOperation = alu_code;
            instr_done   = done;
            illegal_op   = op_illegal | funct_illegal;
        end
    end

endmodule
